// File: rtl/arb_rr_4.sv
// Four-way round-robin arbiter with bounded grant hold and a mandatory dead cycle
// between grants. All outputs come straight from registers.
module arb_rr_4 #(
  parameter int MAX_HOLD = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [3:0] req,
  output logic [3:0] gnt,
  output logic [1:0] gnt_id,
  output logic       busy
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  localparam logic [3:0] HOLD_LAST = 4'(MAX_HOLD - 1);

  state_t     state_reg, state_next;
  logic [1:0] ptr_reg, ptr_next;
  logic [1:0] gnt_id_reg, gnt_id_next;
  logic [3:0] hold_cnt_reg, hold_cnt_next;
  logic [3:0] gnt_reg, gnt_next;
  logic       busy_reg, busy_next;

  logic [3:0] rot_req;
  logic [1:0] win_off;
  logic [1:0] winner;
  logic [3:0] win_onehot;
  logic       others_pending;
  logic       leave_grant;

  // rot_req[k] is the request k places after ptr, so bit 0 has top priority
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_rot
      localparam logic [1:0] OFF = 2'(gi);
      logic [1:0] idx;
      assign idx            = ptr_reg + OFF;
      assign rot_req[gi]    = req[idx];
      assign win_onehot[gi] = (winner == OFF);
    end
  endgenerate

  always_comb begin
    if (rot_req[0])      win_off = 2'd0;
    else if (rot_req[1]) win_off = 2'd1;
    else if (rot_req[2]) win_off = 2'd2;
    else                 win_off = 2'd3;
  end

  assign winner         = ptr_reg + win_off;
  assign others_pending = |(req & ~gnt_reg);
  assign leave_grant    = !en || !req[gnt_id_reg] ||
                          ((hold_cnt_reg == HOLD_LAST) && others_pending);

  always_comb begin
    state_next    = state_reg;
    ptr_next      = ptr_reg;
    gnt_id_next   = gnt_id_reg;
    hold_cnt_next = hold_cnt_reg;
    gnt_next      = gnt_reg;
    busy_next     = busy_reg;
    unique case (state_reg)
      IDLE: begin
        gnt_next      = 4'b0000;
        busy_next     = 1'b0;
        hold_cnt_next = 4'd0;
        if (en && (|req)) begin
          state_next  = GRANT;
          gnt_id_next = winner;
          gnt_next    = win_onehot;
          busy_next   = 1'b1;
          ptr_next    = winner + 2'd1;
        end
      end
      GRANT: begin
        if (leave_grant) begin
          // Always pass through IDLE so grants never switch directly
          state_next    = IDLE;
          gnt_next      = 4'b0000;
          busy_next     = 1'b0;
          hold_cnt_next = 4'd0;
        end else if (hold_cnt_reg != HOLD_LAST) begin
          hold_cnt_next = hold_cnt_reg + 4'd1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      ptr_reg      <= 2'd0;
      gnt_id_reg   <= 2'd0;
      hold_cnt_reg <= 4'd0;
      gnt_reg      <= 4'b0000;
      busy_reg     <= 1'b0;
    end else begin
      state_reg    <= state_next;
      ptr_reg      <= ptr_next;
      gnt_id_reg   <= gnt_id_next;
      hold_cnt_reg <= hold_cnt_next;
      gnt_reg      <= gnt_next;
      busy_reg     <= busy_next;
    end
  end

  assign gnt    = gnt_reg;
  assign gnt_id = gnt_id_reg;
  assign busy   = busy_reg;

endmodule

// File: tb/tb_arb_rr_4.sv
// Directed vector table plus multi-cycle sequences and a randomized invariant
// checker for arb_rr_4 (MAX_HOLD = 8).
module tb_arb_rr_4;

  localparam int MAX_HOLD = 8;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic [3:0] req;
  logic [3:0] gnt;
  logic [1:0] gnt_id;
  logic       busy;

  int n_cmp = 0;
  int n_bad = 0;

  arb_rr_4 #(.MAX_HOLD(MAX_HOLD)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (en),
    .req    (req),
    .gnt    (gnt),
    .gnt_id (gnt_id),
    .busy   (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       en;
    logic [3:0] req;
    logic [3:0] gnt;
    logic [1:0] id;
    logic       busy;
  } vec_t;

  vec_t vecs[16];

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // Apply inputs, let one rising edge sample them, then settle past the edge
  task automatic step(input logic e, input logic [3:0] r);
    en  = e;
    req = r;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    en    = 1'b0;
    req   = 4'b0000;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [3:0] exp_g;
    logic [3:0] r;
    logic       e;
    logic [3:0] prev_g;
    int         run_len;
    logic       pend;
    logic [3:0] ok;

    // Starting from reset: ptr=0, IDLE
    vecs[0]  = '{1'b1, 4'b0000, 4'b0000, 2'd0, 1'b0};
    vecs[1]  = '{1'b0, 4'b1111, 4'b0000, 2'd0, 1'b0};
    vecs[2]  = '{1'b1, 4'b0100, 4'b0100, 2'd2, 1'b1};
    vecs[3]  = '{1'b1, 4'b0100, 4'b0100, 2'd2, 1'b1};
    vecs[4]  = '{1'b1, 4'b0100, 4'b0100, 2'd2, 1'b1};
    vecs[5]  = '{1'b1, 4'b0000, 4'b0000, 2'd2, 1'b0};
    vecs[6]  = '{1'b1, 4'b0001, 4'b0001, 2'd0, 1'b1};
    vecs[7]  = '{1'b1, 4'b1001, 4'b0001, 2'd0, 1'b1};
    vecs[8]  = '{1'b1, 4'b1000, 4'b0000, 2'd0, 1'b0};
    vecs[9]  = '{1'b1, 4'b1010, 4'b0010, 2'd1, 1'b1};
    vecs[10] = '{1'b0, 4'b1010, 4'b0000, 2'd1, 1'b0};
    vecs[11] = '{1'b0, 4'b1010, 4'b0000, 2'd1, 1'b0};
    vecs[12] = '{1'b1, 4'b1010, 4'b1000, 2'd3, 1'b1};
    vecs[13] = '{1'b1, 4'b0010, 4'b0000, 2'd3, 1'b0};
    vecs[14] = '{1'b1, 4'b0010, 4'b0010, 2'd1, 1'b1};
    vecs[15] = '{1'b1, 4'b0000, 4'b0000, 2'd1, 1'b0};

    en    = 1'b0;
    req   = 4'b0000;
    do_reset();
    #1;
    check("reset_gnt", 8'(gnt), 8'h00);
    check("reset_id", 8'(gnt_id), 8'h00);
    check("reset_busy", 8'(busy), 8'h00);

    for (int i = 0; i < 16; i++) begin
      step(vecs[i].en, vecs[i].req);
      $display("vec %0d en=%b req=%b -> gnt=%b id=%0d busy=%b", i, vecs[i].en, vecs[i].req,
               gnt, gnt_id, busy);
      check($sformatf("vec%0d_gnt", i), 8'(gnt), 8'(vecs[i].gnt));
      check($sformatf("vec%0d_id", i), 8'(gnt_id), 8'(vecs[i].id));
      check($sformatf("vec%0d_busy", i), 8'(busy), 8'(vecs[i].busy));
    end

    // All four requesting: 8-cycle grants in order 0,1,2,3,0 with one idle gap
    do_reset();
    for (int k = 1; k <= 40; k++) begin
      step(1'b1, 4'b1111);
      if ((k - 1) % 9 == 8) exp_g = 4'b0000;
      else                  exp_g = 4'b0001 << (((k - 1) / 9) % 4);
      check($sformatf("rr_all_c%0d", k), 8'(gnt), 8'(exp_g));
    end
    $display("seq rr_all done");

    // Lone requester is never preempted
    do_reset();
    for (int k = 1; k <= 30; k++) begin
      step(1'b1, 4'b0001);
      check($sformatf("lone_c%0d", k), 8'(gnt), 8'h01);
    end
    $display("seq lone done");

    // Preemption, then simultaneous release+preemption; preempted goes last
    do_reset();
    for (int k = 1; k <= 19; k++) begin
      step(1'b1, (k == 18) ? 4'b0001 : 4'b0011);
      if (k <= 8)       exp_g = 4'b0001;
      else if (k == 9)  exp_g = 4'b0000;
      else if (k <= 17) exp_g = 4'b0010;
      else if (k == 18) exp_g = 4'b0000;
      else              exp_g = 4'b0001;
      check($sformatf("preempt_c%0d", k), 8'(gnt), 8'(exp_g));
    end
    $display("seq preempt done");

    // Disable mid-grant of id 1; resume from retained ptr=2 -> id 0
    do_reset();
    step(1'b1, 4'b0010);
    check("en_gnt1", 8'(gnt), 8'h02);
    step(1'b1, 4'b0011);
    check("en_hold1", 8'(gnt), 8'h02);
    for (int k = 0; k < 3; k++) begin
      step(1'b0, 4'b0011);
      check($sformatf("en_off%0d_gnt", k), 8'(gnt), 8'h00);
      check($sformatf("en_off%0d_busy", k), 8'(busy), 8'h00);
    end
    step(1'b1, 4'b0011);
    check("en_resume_gnt", 8'(gnt), 8'h01);
    check("en_resume_id", 8'(gnt_id), 8'h00);
    $display("seq en_low done");

    // Asynchronous reset between edges while id 3 is granted
    do_reset();
    step(1'b1, 4'b1000);
    check("arst_pre_gnt", 8'(gnt), 8'h08);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_gnt", 8'(gnt), 8'h00);
    check("arst_busy", 8'(busy), 8'h00);
    check("arst_id", 8'(gnt_id), 8'h00);
    en  = 1'b1;
    req = 4'b1010;
    @(posedge clk);
    #1;
    check("arst_held", 8'(gnt), 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("arst_first_gnt", 8'(gnt), 8'h02);
    check("arst_first_id", 8'(gnt_id), 8'h01);
    $display("seq async_reset done");

    // Random invariant checking with slowly changing inputs
    do_reset();
    r       = 4'b0000;
    e       = 1'b1;
    prev_g  = 4'b0000;
    run_len = 0;
    for (int k = 0; k < 10000; k++) begin
      if ($urandom_range(0, 7) == 0)  r = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 31) == 0) e = ~e;
      pend = |(r & ~prev_g);
      step(e, r);
      ok[3] = ((gnt & (gnt - 4'd1)) == 4'b0000);
      ok[2] = (busy == (|gnt));
      ok[1] = !((prev_g != 4'b0000) && (gnt != 4'b0000) && (gnt != prev_g));
      ok[0] = !((prev_g != 4'b0000) && (run_len >= MAX_HOLD) && pend && (gnt != 4'b0000));
      check($sformatf("rand_c%0d", k), 8'(ok), 8'h0f);
      if (gnt != 4'b0000 && gnt == prev_g) run_len++;
      else if (gnt != 4'b0000)             run_len = 1;
      else                                 run_len = 0;
      prev_g = gnt;
    end
    $display("seq random done");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/arb_rr_4.md
ARB_RR_4 -- requirements
Module: arb_rr_4

Interface
REQ-001 Parameter MAX_HOLD, default 8: maximum consecutive cycles one grant is held while any other request is pending; legal range 2..15.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 en  input  1  arbiter enable; low forces all grants off.
REQ-005 req  input  4  request lines; req[i] from requester i.
REQ-006 gnt  output  4  one-hot grant; gnt[i] to requester i; 0000 when no grant.
REQ-007 gnt_id  output  2  binary index of current/last grantee.
REQ-008 busy  output  1  high exactly when gnt is non-zero.

Function
REQ-009 The block SHALL implement two states, IDLE and GRANT; all outputs SHALL be registered, with no combinational path from inputs to outputs.
REQ-010 gnt SHALL equal the one-hot decode of gnt_id when busy=1, and SHALL be 0000 when busy=0.
REQ-011 A 2-bit pointer ptr SHALL hold the highest-priority index; priority order SHALL be ptr, ptr+1, ptr+2, ptr+3 (mod 4).
REQ-012 IDLE with en=1 and req!=0: the first set req bit in priority order SHALL become the winner; next edge: state GRANT, gnt_id=winner, busy=1, ptr=winner+1 mod 4, hold_cnt=0.
REQ-013 IDLE with en=0 or req=0: the block SHALL remain in IDLE with gnt=0000, busy=0, gnt_id unchanged.
REQ-014 Grant latency SHALL be exactly 1 cycle, from the edge sampling the request to the edge asserting gnt.
REQ-015 GRANT: hold_cnt SHALL increment by 1 each cycle the grant is held and saturate at MAX_HOLD-1.
REQ-016 GRANT: the block SHALL go to IDLE on the next edge (gnt=0000, busy=0, hold_cnt=0) when any of these holds:
  - req[gnt_id]=0 (release)
  - en=0
  - hold_cnt=MAX_HOLD-1 and any other req bit is set (preemption)
REQ-017 GRANT with hold_cnt=MAX_HOLD-1 and no other request pending: the block SHALL hold the grant indefinitely.
REQ-018 Every GRANT-to-IDLE transition SHALL produce exactly one dead cycle with gnt=0000 before any new grant; a back-to-back grant SHALL never change gnt directly from one one-hot value to another.
REQ-019 Re-arbitration after release or preemption SHALL use the updated ptr, so a preempted requester with req still high SHALL have lowest priority.
REQ-020 Simultaneous release and preemption in the same cycle SHALL be treated identically: go to IDLE.
REQ-021 en=0 SHALL not alter ptr; arbitration SHALL resume from the retained ptr when en returns high.
REQ-022 At most one gnt bit SHALL be high in any cycle.

Reset
REQ-023 rst_n=0 SHALL immediately, without waiting for clk, force: state=IDLE, gnt=0000, gnt_id=00, busy=0, ptr=00, hold_cnt=0.
REQ-024 Reset asserted during GRANT SHALL drop gnt in the same cycle; after deassertion, the first arbitration SHALL start from ptr=00.
REQ-025 Reset deassertion SHALL take effect synchronously on the next rising clk edge.

Verification
REQ-026 Reset, then en=1, req=1111 held for 40 cycles, MAX_HOLD=8 -> grants id 0,1,2,3,0 in order; each held 8 cycles; one 0000 cycle between consecutive grants.
REQ-027 en=1, req=0100 asserted at edge t -> gnt=0100, gnt_id=10, busy=1 at edge t+1; req dropped at edge t+3 -> gnt=0000 at edge t+4.
REQ-028 Single requester req=0001 held for 30 cycles -> gnt=0001 continuously, with no preemption.
REQ-029 Mid-grant of id 1, en driven low for 3 cycles with req=0011 -> gnt=0000 the next cycle; after en returns high, first grant is id 0 (ptr=2 wraps to 0), not id 1.
REQ-030 rst_n pulsed low between clock edges while gnt=1000 -> gnt=0000 and busy=0 before the next edge; after release with req=1010, first grant is 0010.
REQ-031 Random req/en stimulus for 10k cycles -> checker confirms one-hot or zero gnt, busy==|gnt, no direct grant-to-grant change, and no hold longer than MAX_HOLD while others are pending.
